// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional statistics counters are enabled with DMEM_RSP_STATS_EN.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_rsp_state_e;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic r;
    r = 1'b0;
    case (funct3)
      LH, LHU: r = addr[0];
      LW:      r = (addr != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/data and load extract/extend.
// Purely combinational; used by dmem_wait_responder.
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [31:0] sh;

  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    sh    = word >> {offset, 3'b000};
    rdata = 32'h0;
    case (funct3)
      LB:      rdata = {{24{sh[7]}}, sh[7:0]};
      LH:      rdata = {{16{sh[15]}}, sh[15:0]};
      LW:      rdata = word;
      LBU:     rdata = {24'h0, sh[7:0]};
      LHU:     rdata = {16'h0, sh[15:0]};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Word RAM responder with programmable wait states behind valid/ready.
// Define DMEM_RSP_STATS_EN to enable the load/store completion counters.
module dmem_wait_responder
  import rv_mem_pkg::*;
#(
  parameter int NUM_WORDS   = 128,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [31:0] mem [NUM_WORDS];

  dmem_rsp_state_e  state;
  logic [3:0]       cnt;
  logic             we_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             use_req;
  logic             we_s;
  logic             err_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic [2:0]       f3_s;
  logic [31:0]      wdata_s;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic [31:0]      ld_data;
  logic             unused_addr;

  assign accept  = req_valid & req_ready;
  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

  // In IDLE the live request feeds the datapath so zero wait states work.
  assign use_req = (state == IDLE);
  assign we_s    = use_req ? req_we : we_q;
  assign idx_s   = use_req ? req_addr[IDX_W+1:2] : idx_q;
  assign off_s   = use_req ? req_addr[1:0] : off_q;
  assign f3_s    = use_req ? req_funct3 : f3_q;
  assign wdata_s = use_req ? req_wdata : wdata_q;
  assign err_s   = use_req
                 ? (is_misaligned(req_funct3, req_addr[1:0]) |
                    is_illegal(req_funct3))
                 : err_q;

  dmem_lane_align u_align (
    .funct3 (f3_s),
    .offset (off_s),
    .wdata  (wdata_s),
    .word   (mem[idx_s]),
    .be     (be),
    .wlane  (wlane),
    .rdata  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            idx_q     <= idx_s;
            off_q     <= off_s;
            f3_q      <= f3_s;
            wdata_q   <= wdata_s;
            err_q     <= err_s;
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err_s;
              rsp_rdata <= (we_s | err_s) ? 32'h0 : ld_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_s;
            rsp_rdata <= (we_s | err_s) ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == RESP && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

`ifdef DMEM_RSP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= 32'h0;
      stat_stores <= 32'h0;
    end else if (state == RESP) begin
      if (we_q) stat_stores <= stat_stores + 32'd1;
      else      stat_loads  <= stat_loads + 32'd1;
    end
  end
`else
  assign stat_loads  = 32'h0;
  assign stat_stores = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed scoreboard bench for dmem_wait_responder (WAIT_STATES=2).
// Stats checks follow DMEM_RSP_STATS_EN when it is defined.
module tb_dmem_wait_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   nloads = 0;
  int   nstores = 0;

  dmem_wait_responder #(
    .NUM_WORDS   (128),
    .WAIT_STATES (WS),
    .ADDR_W      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
  endtask

  task automatic xfer(input string tag, input logic we,
                      input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] er,
                      input logic ee);
    int   n;
    exp_t e;
    drive(we, addr, f3, wd);
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_accept"}, 32'(req_ready), 32'd1);
    e.rdata = er;
    e.err   = ee;
    sbq.push_back(e);
    if (we) nstores++;
    else    nloads++;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(WS));
    e = sbq.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    step();
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   hs;
    int   rs;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_funct3 = 3'b010;
    req_wdata = 32'h0;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_sloads", stat_loads, 32'h0);
    check("rst_sstores", stat_stores, 32'h0);

    xfer("sw10", 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    xfer("lw10", 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    xfer("sb11", 1, 32'h11, 3'b000, 32'h12345680, 32'h0, 0);
    xfer("lw10b", 0, 32'h10, 3'b010, 32'h0, 32'hDEAD80EF, 0);
    xfer("lb11", 0, 32'h11, 3'b000, 32'h0, 32'hFFFFFF80, 0);
    xfer("lbu11", 0, 32'h11, 3'b100, 32'h0, 32'h00000080, 0);
    xfer("sh12", 1, 32'h12, 3'b001, 32'h00001234, 32'h0, 0);
    xfer("lh13", 0, 32'h13, 3'b001, 32'h0, 32'h0, 1);
    xfer("lw10c", 0, 32'h10, 3'b010, 32'h0, 32'h123480EF, 0);
    xfer("lhu12", 0, 32'h12, 3'b101, 32'h0, 32'h00001234, 0);
    xfer("lh10", 0, 32'h10, 3'b001, 32'h0, 32'hFFFF80EF, 0);
    xfer("sw11", 1, 32'h11, 3'b010, 32'hCAFEF00D, 32'h0, 1);
    xfer("ill3", 0, 32'h10, 3'b011, 32'h0, 32'h0, 1);
    xfer("lw10d", 0, 32'h10, 3'b010, 32'h0, 32'h123480EF, 0);
    xfer("lwwrap", 0, 32'h210, 3'b010, 32'h0, 32'h123480EF, 0);

    // back-to-back with req_valid held
    drive(0, 32'h10, 3'b010, 32'h0);
    hs = 0;
    rs = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        rs++;
        e = sbq.pop_front();
        check("b2b_rdata", rsp_rdata, e.rdata);
        check("b2b_ready", 32'(req_ready), 32'd0);
      end
      if (req_ready) begin
        hs++;
        nloads++;
        e.rdata = 32'h123480EF;
        e.err   = 1'b0;
        sbq.push_back(e);
      end
      if (c == 11) req_valid = 1'b0;
      step();
    end
    check("b2b_accepts", 32'(hs), 32'd3);
    check("b2b_rsps", 32'(rs), 32'd3);
    check("b2b_sbq", 32'(sbq.size()), 32'd0);
    check("b2b_idle", 32'(req_ready), 32'd1);

    // reset during WAIT drops the store
    xfer("sw20", 1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0);
    drive(1, 32'h20, 3'b010, 32'h00000055);
    step();
    req_valid = 1'b0;
    check("rstw_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nloads  = 0;
    nstores = 0;
    rs = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) rs++;
      step();
    end
    check("rstw_norsp", 32'(rs), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_sloads", stat_loads, 32'h0);
    xfer("lw20", 0, 32'h20, 3'b010, 32'h0, 32'h11223344, 0);
    xfer("sb23", 1, 32'h23, 3'b000, 32'h000000A5, 32'h0, 0);
    xfer("lw20b", 0, 32'h20, 3'b010, 32'h0, 32'hA5223344, 0);
    xfer("sh22", 1, 32'h22, 3'b001, 32'h0000BEEF, 32'h0, 0);
    xfer("lb22", 0, 32'h22, 3'b000, 32'h0, 32'hFFFFFFEF, 0);

`ifdef DMEM_RSP_STATS_EN
    check("stat_loads", stat_loads, 32'(nloads));
    check("stat_stores", stat_stores, 32'(nstores));
`else
    check("stat_loads", stat_loads, 32'h0);
    check("stat_stores", stat_stores, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
